sipo_deframer: RTL

Serial-in/parallel-out receiver that sits directly downstream of the 4-bit parallel-in/serial-out shifter. It consumes that stage's serial output, MSB first, and reassembles WIDTH-bit words. Completed words go to a parallel consumer over a valid/ready handshake. It provides frame alignment via a start strobe, bit-gating via bit_en, and sticky overrun detection.

---
 rtl/sipo_deframer_if.sv | 37 +++
 rtl/sipo_deframer.sv | 92 +++++++++
 2 files changed

// File: rtl/sipo_deframer_if.sv
// Bundle of the serial-input and parallel-output signals of sipo_deframer.
// The master modport is the deframer itself; the slave modport is whoever
// feeds serial bits in and consumes the reassembled words.
interface sipo_deframer_if #(
    parameter int WIDTH = 4
);
    logic             sin;
    logic             bit_en;
    logic             start;
    logic [WIDTH-1:0] pout;
    logic             pvalid;
    logic             pready;
    logic             busy;
    logic             overrun;

    modport master (
        input  sin,
        input  bit_en,
        input  start,
        input  pready,
        output pout,
        output pvalid,
        output busy,
        output overrun
    );

    modport slave (
        output sin,
        output bit_en,
        output start,
        output pready,
        input  pout,
        input  pvalid,
        input  busy,
        input  overrun
    );
endinterface

// File: rtl/sipo_deframer.sv
// Serial-in/parallel-out deframer: collects MSB-first serial bits into
// WIDTH-bit words, aligned by a start strobe and qualified by bit_en, and
// hands completed words out over a valid/ready handshake with sticky overrun.
module sipo_deframer #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    sipo_deframer_if.master      bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-2:0] shreg, shreg_n;
    logic [CW-1:0]    count, count_n;
    logic [WIDTH-1:0] pout_n;
    logic             pvalid_n;
    logic             overrun_n;
    logic [WIDTH-1:0] shifted;
    logic             complete;

    // Register all state; reset discards any partial word and clears outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            count       <= '0;
            bus.pout    <= '0;
            bus.pvalid  <= 1'b0;
            bus.overrun <= 1'b0;
        end else begin
            state       <= state_n;
            shreg       <= shreg_n;
            count       <= count_n;
            bus.pout    <= pout_n;
            bus.pvalid  <= pvalid_n;
            bus.overrun <= overrun_n;
        end
    end

    // Next-state logic: bit capture, word completion and output handshake.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        count_n   = count;
        pout_n    = bus.pout;
        pvalid_n  = bus.pvalid;
        overrun_n = bus.overrun;
        complete  = 1'b0;
        shifted   = {shreg, bus.sin};

        if (bus.start) begin
            state_n = SHIFT;
            shreg_n = '0;
            count_n = '0;
            if (bus.bit_en) begin
                shreg_n[0] = bus.sin;
                count_n    = CW'(1);
            end
        end else if (state == SHIFT && bus.bit_en) begin
            if (count == CW'(WIDTH - 1)) begin
                complete = 1'b1;
                pout_n   = shifted;
                state_n  = IDLE;
                count_n  = '0;
                shreg_n  = '0;
            end else begin
                shreg_n = shifted[WIDTH-2:0];
                count_n = count + 1'b1;
            end
        end

        if (complete) begin
            pvalid_n = 1'b1;
            if (bus.pvalid && !bus.pready) begin
                overrun_n = 1'b1;
            end
        end else if (bus.pvalid && bus.pready) begin
            pvalid_n = 1'b0;
        end
    end

    // A word is in progress whenever the frame has been aligned by start.
    always_comb begin
        bus.busy = (state == SHIFT);
    end
endmodule
